// File: rtl/wbu.sv
// Writeback unit: selects ALU or formatted load data and drives the register
// file write port from a single registered stage. Also tracks pending writes.
module wbu #(
  parameter int unsigned CPU_WIDTH = 64,
  parameter int unsigned REG_ADDRW = 5,
  parameter int unsigned REG_COUNT = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [REG_ADDRW-1:0] i_rd,
  input  logic                 i_rd_wen,
  input  logic                 i_is_load,
  input  logic [CPU_WIDTH-1:0] i_alu_res,
  input  logic [CPU_WIDTH-1:0] i_ld_raw,
  input  logic [2:0]           i_ld_funct,
  input  logic [2:0]           i_ld_off,
  input  logic                 i_issue,
  input  logic [REG_ADDRW-1:0] i_issue_rd,
  input  logic                 i_flush,
  output logic                 o_wen,
  output logic [REG_ADDRW-1:0] o_waddr,
  output logic [CPU_WIDTH-1:0] o_wdata,
  output logic [REG_COUNT-1:0] o_busy,
  output logic                 o_ld_err,
  output logic [63:0]          o_retire_cnt
);

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LD  = 3'b011;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;
  localparam logic [2:0] F_LWU = 3'b110;

  logic                 wen_q, wen_d;
  logic                 drop_q, drop_d;
  logic [REG_ADDRW-1:0] waddr_q, waddr_d;
  logic [CPU_WIDTH-1:0] wdata_q, wdata_d;
  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic                 ld_err_q, ld_err_d;
  logic [63:0]          cnt_q, cnt_d;

  logic                 xfer;
  logic [CPU_WIDTH-1:0] sh;
  logic [CPU_WIDTH-1:0] ld_data;
  logic                 ld_bad;
  logic                 err;
  logic [CPU_WIDTH-1:0] result;

  assign o_ready = !i_rst && !i_flush;
  assign xfer    = i_valid && o_ready;

  // Load byte-lane alignment, extension and alignment check
  always_comb begin
    sh      = i_ld_raw >> {i_ld_off, 3'b000};
    ld_data = sh;
    ld_bad  = 1'b0;
    case (i_ld_funct)
      F_LB:  ld_data = {{(CPU_WIDTH-8){sh[7]}}, sh[7:0]};
      F_LBU: ld_data = {{(CPU_WIDTH-8){1'b0}}, sh[7:0]};
      F_LH: begin
        ld_data = {{(CPU_WIDTH-16){sh[15]}}, sh[15:0]};
        ld_bad  = i_ld_off[0];
      end
      F_LHU: begin
        ld_data = {{(CPU_WIDTH-16){1'b0}}, sh[15:0]};
        ld_bad  = i_ld_off[0];
      end
      F_LW: begin
        ld_data = {{(CPU_WIDTH-32){sh[31]}}, sh[31:0]};
        ld_bad  = |i_ld_off[1:0];
      end
      F_LWU: begin
        ld_data = {{(CPU_WIDTH-32){1'b0}}, sh[31:0]};
        ld_bad  = |i_ld_off[1:0];
      end
      F_LD: begin
        ld_data = sh;
        ld_bad  = |i_ld_off;
      end
      default: ld_bad = 1'b1;
    endcase
    err    = i_is_load && ld_bad;
    result = i_is_load ? ld_data : i_alu_res;
  end

  // Next-state for stage, scoreboard and retire counter
  always_comb begin
    wen_d    = xfer && i_rd_wen && (i_rd != '0) && !err;
    drop_d   = xfer && i_rd_wen && err;
    waddr_d  = xfer ? i_rd : waddr_q;
    wdata_d  = xfer ? result : wdata_q;
    ld_err_d = xfer && err;
    cnt_d    = cnt_q + 64'(xfer);
    busy_d   = busy_q;
    for (int k = 1; k < REG_COUNT; k++) begin
      if ((wen_q || drop_q) && (waddr_q == REG_ADDRW'(k))) busy_d[k] = 1'b0;
      if (i_issue && (i_issue_rd == REG_ADDRW'(k)))        busy_d[k] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (i_flush) busy_d = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wen_q    <= 1'b0;
      drop_q   <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      busy_q   <= '0;
      ld_err_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wen_q    <= wen_d;
      drop_q   <= drop_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      ld_err_q <= ld_err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_wen        = wen_q;
  assign o_waddr      = waddr_q;
  assign o_wdata      = wdata_q;
  assign o_busy       = busy_q;
  assign o_ld_err     = ld_err_q;
  assign o_retire_cnt = cnt_q;

endmodule

// File: tb/tb_wbu.sv
// Directed bench for wbu: table of single-packet vectors plus scoreboard,
// flush and async-reset sequences.
module tb_wbu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        ready;
  logic [4:0]  rd = '0;
  logic        rd_wen = 1'b0;
  logic        is_load = 1'b0;
  logic [63:0] alu_res = '0;
  logic [63:0] ld_raw = 64'h8877_6655_4433_2211;
  logic [2:0]  ld_funct = '0;
  logic [2:0]  ld_off = '0;
  logic        issue = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        flush = 1'b0;
  logic        wen;
  logic [4:0]  waddr;
  logic [63:0] wdata;
  logic [31:0] busy;
  logic        ld_err;
  logic [63:0] retire_cnt;

  int n_vec = 0;
  int n_bad = 0;
  logic [63:0] exp_cnt = '0;

  always #5 clk = ~clk;

  wbu dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
    .i_rd(rd), .i_rd_wen(rd_wen), .i_is_load(is_load), .i_alu_res(alu_res),
    .i_ld_raw(ld_raw), .i_ld_funct(ld_funct), .i_ld_off(ld_off),
    .i_issue(issue), .i_issue_rd(issue_rd), .i_flush(flush),
    .o_wen(wen), .o_waddr(waddr), .o_wdata(wdata), .o_busy(busy),
    .o_ld_err(ld_err), .o_retire_cnt(retire_cnt)
  );

  typedef struct {
    logic        is_load;
    logic [2:0]  funct;
    logic [2:0]  off;
    logic [4:0]  rd;
    logic [63:0] alu;
    logic        exp_wen;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_alu(input logic [4:0] r, input logic [63:0] v);
    valid = 1'b1; is_load = 1'b0; rd = r; rd_wen = 1'b1; alu_res = v;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 3'b000, 3'd0, 5'd5,  64'h1234, 1'b1, 64'h1234, 1'b0};
    tbl[1]  = '{1'b1, 3'b000, 3'd7, 5'd1,  64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FF88, 1'b0};
    tbl[2]  = '{1'b1, 3'b101, 3'd2, 5'd2,  64'h0, 1'b1, 64'h4433, 1'b0};
    tbl[3]  = '{1'b1, 3'b010, 3'd4, 5'd4,  64'h0, 1'b1, 64'hFFFF_FFFF_8877_6655, 1'b0};
    tbl[4]  = '{1'b1, 3'b011, 3'd0, 5'd6,  64'h0, 1'b1, 64'h8877_6655_4433_2211, 1'b0};
    tbl[5]  = '{1'b1, 3'b100, 3'd7, 5'd8,  64'h0, 1'b1, 64'h88, 1'b0};
    tbl[6]  = '{1'b1, 3'b001, 3'd6, 5'd9,  64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_8877, 1'b0};
    tbl[7]  = '{1'b1, 3'b110, 3'd4, 5'd10, 64'h0, 1'b1, 64'h8877_6655, 1'b0};
    tbl[8]  = '{1'b1, 3'b010, 3'd0, 5'd11, 64'h0, 1'b1, 64'h4433_2211, 1'b0};
    tbl[9]  = '{1'b1, 3'b010, 3'd2, 5'd12, 64'h0, 1'b0, 64'h0, 1'b1};
    tbl[10] = '{1'b1, 3'b111, 3'd0, 5'd13, 64'h0, 1'b0, 64'h0, 1'b1};
    tbl[11] = '{1'b1, 3'b011, 3'd4, 5'd14, 64'h0, 1'b0, 64'h0, 1'b1};
    tbl[12] = '{1'b1, 3'b001, 3'd1, 5'd15, 64'h0, 1'b0, 64'h0, 1'b1};
    tbl[13] = '{1'b1, 3'b000, 3'd3, 5'd16, 64'hDEAD, 1'b1, 64'h44, 1'b0};
    tbl[14] = '{1'b0, 3'b111, 3'd1, 5'd0,  64'h99, 1'b0, 64'h0, 1'b0};

    // Reset state
    step(); step();
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_wen", 64'(wen), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_wdata", wdata, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt", retire_cnt, 64'd0);
    rst = 1'b0;
    #1;
    chk("ready", 64'(ready), 64'd1);

    // Vector table, back-to-back
    for (int i = 0; i < 15; i++) begin
      valid = 1'b1; rd_wen = 1'b1;
      is_load = tbl[i].is_load; ld_funct = tbl[i].funct; ld_off = tbl[i].off;
      rd = tbl[i].rd; alu_res = tbl[i].alu;
      step();
      exp_cnt++;
      chk($sformatf("v%0d_wen", i), 64'(wen), 64'(tbl[i].exp_wen));
      chk($sformatf("v%0d_err", i), 64'(ld_err), 64'(tbl[i].exp_err));
      chk($sformatf("v%0d_waddr", i), 64'(waddr), 64'(tbl[i].rd));
      if (tbl[i].exp_wen) chk($sformatf("v%0d_wdata", i), wdata, tbl[i].exp_data);
      chk($sformatf("v%0d_cnt", i), retire_cnt, exp_cnt);
    end
    valid = 1'b0;
    step();
    chk("idle_wen", 64'(wen), 64'd0);
    chk("idle_err", 64'(ld_err), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Scoreboard set
    issue = 1'b1; issue_rd = 5'd7; step();
    chk("sb_set7", 64'(busy), 64'h80);
    issue_rd = 5'd3; step(); issue = 1'b0;
    chk("sb_set3", 64'(busy), 64'h88);

    // Misaligned load drops write and clears busy[3]
    valid = 1'b1; is_load = 1'b1; ld_funct = 3'b010; ld_off = 3'd2; rd = 5'd3; rd_wen = 1'b1;
    step(); valid = 1'b0; exp_cnt++;
    chk("mis_wen", 64'(wen), 64'd0);
    chk("mis_err", 64'(ld_err), 64'd1);
    chk("mis_busy_n1", 64'(busy), 64'h88);
    step();
    chk("mis_err_pulse", 64'(ld_err), 64'd0);
    chk("mis_busy_n2", 64'(busy), 64'h80);
    chk("mis_cnt", retire_cnt, exp_cnt);

    // Retire rd=7 while re-issuing rd=7: set wins
    send_alu(5'd7, 64'hAA); step(); valid = 1'b0; exp_cnt++;
    chk("rt7_wen", 64'(wen), 64'd1);
    chk("rt7_waddr", 64'(waddr), 64'd7);
    issue = 1'b1; issue_rd = 5'd7; step(); issue = 1'b0;
    chk("rt7_setwins", 64'(busy), 64'h80);
    step();
    chk("rt7_hold", 64'(busy), 64'h80);
    send_alu(5'd7, 64'hBB); step(); valid = 1'b0; exp_cnt++;
    chk("rt7b_wen", 64'(wen), 64'd1);
    chk("rt7b_wdata", wdata, 64'hBB);
    step();
    chk("rt7b_clear", 64'(busy), 64'h0);

    // x0 is never busy and never written
    issue = 1'b1; issue_rd = 5'd0; step(); issue = 1'b0;
    chk("x0_issue", 64'(busy), 64'h0);
    send_alu(5'd0, 64'h77); step(); valid = 1'b0; exp_cnt++;
    chk("x0_wen", 64'(wen), 64'd0);
    chk("x0_cnt", retire_cnt, exp_cnt);

    // Flush with valid, issue and busy=0xF0
    issue = 1'b1;
    for (int r = 4; r < 8; r++) begin
      issue_rd = 5'(r); step();
    end
    issue = 1'b0;
    chk("fl_busy_pre", 64'(busy), 64'hF0);
    flush = 1'b1; send_alu(5'd9, 64'h1111); issue = 1'b1; issue_rd = 5'd8;
    #1;
    chk("fl_ready", 64'(ready), 64'd0);
    step(); flush = 1'b0; valid = 1'b0; issue = 1'b0;
    chk("fl_wen", 64'(wen), 64'd0);
    chk("fl_err", 64'(ld_err), 64'd0);
    chk("fl_busy", 64'(busy), 64'h0);
    chk("fl_cnt", retire_cnt, exp_cnt);

    // Async reset mid-stream while o_wen=1
    send_alu(5'd12, 64'h55); step(); valid = 1'b0; exp_cnt++;
    chk("ar_wen_pre", 64'(wen), 64'd1);
    chk("ar_cnt_pre", retire_cnt, exp_cnt);
    #2 rst = 1'b1;
    #1;
    chk("ar_wen", 64'(wen), 64'd0);
    chk("ar_waddr", 64'(waddr), 64'd0);
    chk("ar_wdata", wdata, 64'd0);
    chk("ar_cnt", retire_cnt, 64'd0);
    chk("ar_ready", 64'(ready), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("ar_after_wen", 64'(wen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wbu.md
# wbu

Writeback unit between the execute/load-store stages and the integer register file. Accepts one retiring instruction per cycle over a valid/ready handshake, selects the ALU or load result, aligns and sign/zero-extends load data, and drives the register file's single write port from a registered stage. Also keeps a pending-write scoreboard for hazard detection and a retired-instruction counter for simulation.

## Interface
- `CPU_WIDTH`, 64, datapath width; only 64 is supported.
- `REG_ADDRW`, 5, register address width.
- `REG_COUNT`, 32, register count; scoreboard width.

Ports:
- `i_clk` input 1 — clock, all state on rising edge.
- `i_rst` input 1 — asynchronous, active-high reset.
- `i_valid` input 1 — retiring packet present.
- `o_ready` output 1 — wbu accepts packet this cycle.
- `i_rd` input REG_ADDRW — destination register.
- `i_rd_wen` input 1 — instruction writes rd.
- `i_is_load` input 1 — 1: result from load data, 0: from `i_alu_res`.
- `i_alu_res` input CPU_WIDTH — ALU/CSR result.
- `i_ld_raw` input CPU_WIDTH — aligned 8-byte doubleword read from memory.
- `i_ld_funct` input 3 — RV64 funct3: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu; 111 illegal.
- `i_ld_off` input 3 — address bits [2:0].
- `i_issue` input 1 — decode issues an rd-writing instruction this cycle.
- `i_issue_rd` input REG_ADDRW — its rd.
- `i_flush` input 1 — discard staged packet and clear scoreboard.
- `o_wen` output 1 — register file write enable.
- `o_waddr` output REG_ADDRW — register file write address.
- `o_wdata` output CPU_WIDTH — register file write data.
- `o_busy` output REG_COUNT — bit k = write to xk pending.
- `o_ld_err` output 1 — one-cycle pulse: misaligned/illegal load dropped.
- `o_retire_cnt` output 64 — accepted packet count.

## Operation
- Handshake: transfer when `i_valid && o_ready`. `o_ready = !i_rst && !i_flush`; the register file never back-pressures, so no other stall.
- Stage register: on transfer, compute result and latch `o_waddr`, `o_wdata`; `o_wen` latched as `i_rd_wen && (i_rd != 0) && !err`. No transfer → `o_wen` 0 next cycle; `o_waddr`/`o_wdata` hold.
- Load formatting: `sh = i_ld_raw >> (8*i_ld_off)`; b → bits[7:0], h → [15:0], w → [31:0], d → all 64; signed forms sign-extend, unsigned zero-extend to 64.
- Error (`err`): `i_is_load` and (funct 111, or h with off[0]≠0, or w/wu with off[1:0]≠0, or d with off≠0). Packet still retires and counts; write suppressed; `o_ld_err` pulses the cycle after transfer.
- Non-load packets ignore `i_ld_*`.
- Scoreboard per bit k≠0: set on `i_issue && i_issue_rd==k`; cleared in the cycle `o_wen && o_waddr==k`, and also cleared when an accepted packet with rd=k is dropped (err or `i_rd_wen`=0 is not a clear). Set and clear same k same cycle → set wins (newer instruction). Bit 0 constant 0; issue to x0 ignored.
- `i_flush`: no transfer that cycle; next cycle `o_wen`=0, `o_ld_err`=0; all `o_busy` bits 0 (flush beats issue in the same cycle). A write already showing `o_wen`=1 during the flush cycle still completes.
- `o_retire_cnt` +1 per transfer, wraps at 2^64.

## Timing
- Reset (async assert, sync-safe deassert): `o_wen`=0, `o_waddr`=0, `o_wdata`=0, `o_busy`=0, `o_ld_err`=0, `o_retire_cnt`=0, `o_ready`=0 while reset high.
- Latency: transfer in cycle N → `o_wen`/`o_waddr`/`o_wdata` valid cycle N+1 → register file updated at end of N+1; readable cycle N+2. Busy bit clears visible at cycle N+2.
- Throughput: one packet per cycle, back-to-back to same rd writes in order.
- Reset mid-operation: staged write lost, scoreboard cleared.

## Test plan
- Reset then ALU packet rd=5, res=0x1234, wen=1 → cycle+1: `o_wen`=1, `o_waddr`=5, `o_wdata`=0x1234; `o_retire_cnt`=1.
- Loads from raw 0x8877_6655_4433_2211: lb off=7 → 0xFFFF_FFFF_FFFF_FF88; lhu off=2 → 0x4433; lw off=4 → 0xFFFF_FFFF_8877_6655; ld off=0 → raw.
- Misaligned lw off=2, rd=3 → `o_wen`=0, `o_ld_err` one pulse, busy[3] cleared, count increments.
- Issue rd=7 → busy[7]=1; retire rd=7 while re-issuing rd=7 same cycle as `o_wen` → busy[7] stays 1; packet to rd=0 wen=1 → `o_wen`=0.
- `i_flush` with `i_valid`=1 and busy=0x0000_00F0 → `o_ready`=0, no write next cycle, `o_busy`=0.
- Async reset asserted mid-stream with `o_wen`=1 → all outputs to reset values immediately, before next clock edge.
